// File: rtl/jtpopeye_inputs.sv
// jtpopeye_inputs: PS/2 and joystick merge, per-control debounce, coin pulse and pause toggle
module jtpopeye_inputs #(
  parameter int DEBOUNCE = 4,
  parameter int COIN_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        clr_pause,
  output logic [4:0]  joystick1,
  output logic [4:0]  joystick2,
  output logic [1:0]  start_button,
  output logic        coin_input,
  output logic        dip_pause
);
  localparam int N  = 14;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(COIN_W + 1);
  // control order: right,left,down,up,punch,start1,start2,coin,pause, then P2 right..punch
  logic          primed, strobe, paused;
  logic [8:0]    keys, key_hit;
  logic [N-1:0]  joy_q, raw_q, deb, flip;
  logic [CW-1:0] cnt [N];
  logic [TW-1:0] timer;
  logic          ps2_event, coin_rise, pause_rise;
  logic          unused;
  assign unused     = ^{joy_0[15:10], joy_0[5], joy_1[15:5], ps2_key[8]};
  assign ps2_event  = primed && (ps2_key[10] != strobe);
  assign key_hit    = {ps2_key[7:0] == 8'h0C, ps2_key[7:0] == 8'h04, ps2_key[7:0] == 8'h06,
                       ps2_key[7:0] == 8'h05, ps2_key[7:0] == 8'h14, ps2_key[7:0] == 8'h75,
                       ps2_key[7:0] == 8'h72, ps2_key[7:0] == 8'h6B, ps2_key[7:0] == 8'h74};
  assign coin_rise  = flip[7] && raw_q[7];
  assign pause_rise = flip[8] && raw_q[8];
  for (genvar i = 0; i < N; i++) begin : g_deb
    assign flip[i] = (raw_q[i] != deb[i]) && (cnt[i] == CW'(DEBOUNCE - 1));
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt[i] <= '0;
      else cnt[i] <= (raw_q[i] == deb[i] || flip[i]) ? '0 : cnt[i] + CW'(1);
  end
  // joystick words are registered so keys and sticks see the same latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      primed       <= 1'b0;
      strobe       <= 1'b0;
      keys         <= '0;
      joy_q        <= '0;
      raw_q        <= '0;
      deb          <= '0;
      timer        <= '0;
      paused       <= 1'b0;
      joystick1    <= '1;
      joystick2    <= '1;
      start_button <= '1;
      coin_input   <= 1'b1;
      dip_pause    <= 1'b1;
    end else begin
      primed       <= 1'b1;
      strobe       <= ps2_key[10];
      keys         <= ps2_event ? (keys & ~key_hit) | (key_hit & {9{ps2_key[9]}}) : keys;
      joy_q        <= {joy_1[4:0], joy_0[9:6], joy_0[4:0]};
      raw_q        <= joy_q | {5'b0, keys};
      deb          <= deb ^ flip;
      timer        <= (coin_rise && timer == '0) ? TW'(COIN_W) : (timer != '0 ? timer - TW'(1) : timer);
      paused       <= clr_pause ? 1'b0 : paused ^ pause_rise;
      joystick1    <= ~deb[4:0];
      joystick2    <= ~deb[13:9];
      start_button <= ~deb[6:5];
      coin_input   <= timer == '0;
      dip_pause    <= ~paused;
    end
endmodule

// File: tb/tb_jtpopeye_inputs.sv
// tb_jtpopeye_inputs: directed and random stimulus against a stability-window reference model
module tb_jtpopeye_inputs;
  localparam int D = 4, CWID = 8, L = D + 2;
  logic        clk = 1'b0, rst_n = 1'b1, clr_pause = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy_0 = '0, joy_1 = '0;
  logic [4:0]  joystick1, joystick2;
  logic [1:0]  start_button;
  logic        coin_input, dip_pause;
  int          errors = 0, checks = 0;
  int          jb [9] = '{0, 1, 2, 3, 4, 6, 7, 8, 9};
  logic [7:0]  codes [11] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h05, 8'h06, 8'h04, 8'h0C, 8'h14, 8'h1C, 8'h29};
  logic [8:0]  m_keys;
  logic [13:0] m_deb;
  logic [13:0] hist [$];
  bit          m_primed, m_strobe, m_coin, m_paused, m_clr_prev;
  int          m_crem;
  always #5 clk = ~clk;
  jtpopeye_inputs #(.DEBOUNCE(D), .COIN_W(CWID)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joy_0(joy_0), .joy_1(joy_1),
    .clr_pause(clr_pause), .joystick1(joystick1), .joystick2(joystick2),
    .start_button(start_button), .coin_input(coin_input), .dip_pause(dip_pause));
  function automatic int key_index(logic [7:0] c);
    case (c)
      8'h74: return 0;
      8'h6B: return 1;
      8'h72: return 2;
      8'h75: return 3;
      8'h14: return 4;
      8'h05: return 5;
      8'h06: return 6;
      8'h04: return 7;
      8'h0C: return 8;
      default: return -1;
    endcase
  endfunction
  task automatic model_reset();
    m_keys = '0; m_deb = '0; m_primed = 0; m_strobe = 0;
    m_coin = 1; m_paused = 0; m_clr_prev = 0; m_crem = 0;
    hist = {};
    repeat (L + 1) hist.push_back('0);
  endtask
  // a control's output takes a raw level once that level has been sampled D times in a row,
  // visible L edges after the first of those samples
  task automatic model_step();
    logic [13:0] r, nd;
    bit          same, coin_rise, pause_rise;
    int          idx;
    if (!m_primed) begin
      m_primed = 1; m_strobe = ps2_key[10];
    end else if (ps2_key[10] != m_strobe) begin
      m_strobe = ps2_key[10];
      idx = key_index(ps2_key[7:0]);
      if (idx >= 0) m_keys[idx] = ps2_key[9];
    end
    for (int i = 0; i < 9; i++) r[i] = m_keys[i] | joy_0[jb[i]];
    for (int i = 0; i < 5; i++) r[9 + i] = joy_1[i];
    hist.push_back(r);
    void'(hist.pop_front());
    nd = m_deb;
    for (int b = 0; b < 14; b++) begin
      same = 1;
      for (int k = 1; k < D; k++) if (hist[k][b] != hist[0][b]) same = 0;
      if (same) nd[b] = hist[0][b];
    end
    coin_rise  = nd[7] && !m_deb[7];
    pause_rise = nd[8] && !m_deb[8];
    if (coin_rise && m_coin) m_crem = CWID;
    m_coin = (m_crem == 0);
    if (m_crem > 0) m_crem--;
    if (m_clr_prev) m_paused = 0;
    else if (pause_rise) m_paused = !m_paused;
    m_clr_prev = clr_pause;
    m_deb = nd;
  endtask
  task automatic chk(string tag, logic [4:0] obs, logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("joystick1", joystick1, ~m_deb[4:0]);
    chk("joystick2", joystick2, ~m_deb[13:9]);
    chk("start_button", {3'b0, start_button}, {3'b0, ~m_deb[6:5]});
    chk("coin_input", {4'b0, coin_input}, {4'b0, m_coin});
    chk("dip_pause", {4'b0, dip_pause}, {4'b0, !m_paused});
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_step();
      #1 check_all();
    end
  endtask
  task automatic ps2(logic [7:0] code, bit pressed, bit ext = 0);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_j1", joystick1, 5'b11111);
    chk("async_j2", joystick2, 5'b11111);
    chk("async_misc", {2'b0, start_button, coin_input}, 5'b00111);
    tick(3);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    int lows, pulses;
    bit prev;
    #2 rst_n = 1'b0;
    model_reset();
    tick(3);
    ps2_key[10] = 1'b1;
    #2 rst_n = 1'b1;
    tick(100);
    // key event latency, press then release
    ps2(8'h6B, 1);
    tick(6);
    chk("left_pre", joystick1, 5'b11111);
    tick(1);
    chk("left_on", joystick1, 5'b11101);
    tick(13);
    ps2(8'h6B, 0);
    tick(6);
    chk("left_hold", joystick1, 5'b11101);
    tick(1);
    chk("left_off", joystick1, 5'b11111);
    tick(5);
    // glitch filter on punch
    for (int w = 3; w <= 4; w++) begin
      lows = 0;
      joy_0[4] = 1'b1;
      tick(w);
      joy_0[4] = 1'b0;
      for (int c = 0; c < 15; c++) begin
        tick(1);
        if (!joystick1[4]) lows++;
      end
      chk($sformatf("punch_%0d_lows", w), 5'(lows), (w == 3) ? 5'd0 : 5'd4);
    end
    // coin: one fixed pulse for a long hold, F3 during the pulse ignored
    lows = 0; pulses = 0; prev = 1;
    joy_0[8] = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c == 10) ps2(8'h04, 1);
      if (c == 50) begin joy_0[8] = 1'b0; ps2(8'h04, 0); end
      tick(1);
      if (!coin_input) lows++;
      if (prev && !coin_input) pulses++;
      prev = coin_input;
    end
    chk("coin_lows", 5'(lows), 5'(CWID));
    chk("coin_pulses", 5'(pulses), 5'd1);
    // pause toggles
    for (int p = 0; p < 2; p++) begin
      ps2(8'h0C, 1);
      tick(8);
      chk("pause_press", {4'b0, dip_pause}, (p == 0) ? 5'd0 : 5'd1);
      ps2(8'h0C, 0);
      tick(8);
    end
    ps2(8'h0C, 1);
    tick(5);
    clr_pause = 1'b1;
    tick(1);
    clr_pause = 1'b0;
    tick(10);
    chk("pause_clr_wins", {4'b0, dip_pause}, 5'd1);
    ps2(8'h0C, 0);
    tick(8);
    ps2(8'h0C, 1, 1);
    tick(8);
    clr_pause = 1'b1;
    tick(1);
    clr_pause = 1'b0;
    tick(2);
    chk("pause_cleared", {4'b0, dip_pause}, 5'd1);
    ps2(8'h0C, 0);
    tick(8);
    // reset mid-hold: joystick survives, key state is lost
    ps2(8'h75, 1);
    joy_0[3] = 1'b1;
    tick(10);
    async_reset();
    tick(6);
    chk("up_pre", joystick1, 5'b11111);
    tick(1);
    chk("up_back", joystick1, 5'b10111);
    joy_0[3] = 1'b0;
    tick(10);
    ps2(8'h75, 1);
    tick(10);
    async_reset();
    tick(20);
    chk("up_lost", joystick1, 5'b11111);
    // random phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) joy_0[jb[$urandom_range(0, 8)]] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) joy_1[$urandom_range(0, 4)] ^= 1'b1;
      if ($urandom_range(0, 30) == 0) joy_0[15:10] = 6'($urandom);
      if ($urandom_range(0, 9) == 0) ps2(codes[$urandom_range(0, 10)], 1'($urandom), 1'($urandom));
      clr_pause = ($urandom_range(0, 40) == 0);
      if (c == 1500) async_reset();
      tick(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
